// File: rtl/monitor_memory_arbiter.sv
// Two-port arbiter in front of a single-ported on-chip memory with registered address and 1-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking from IDLE; the default build gives m0 fixed priority on ties.
module monitor_memory_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              last_grant_q, last_grant_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_port_q, rd_port_d;

    logic pend0, pend1;
    logic gnt0, gnt1;
    logic hold_ok;
    logic tie_to_m1;

    assign pend0   = m0_read | m0_write;
    assign pend1   = m1_read | m1_write;
    assign hold_ok = hold_q < HOLD_W'(MAX_HOLD);

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_to_m1 = ~last_grant_q;
`else
    assign tie_to_m1 = 1'b0;
`endif

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            OWN0: begin
                if (pend0 && (!pend1 || hold_ok)) gnt0 = 1'b1;
                else if (pend1)                   gnt1 = 1'b1;
            end
            OWN1: begin
                if (pend1 && (!pend0 || hold_ok)) gnt1 = 1'b1;
                else if (pend0)                   gnt0 = 1'b1;
            end
            default: begin
                if (pend0 && pend1) begin
                    gnt1 = tie_to_m1;
                    gnt0 = ~tie_to_m1;
                end else begin
                    gnt0 = pend0;
                    gnt1 = pend1;
                end
            end
        endcase
        // Nothing is granted while reset is held, whatever the requesters do.
        if (!reset_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        last_grant_d = last_grant_q;
        rd_pend_d    = 1'b0;
        rd_port_d    = rd_port_q;
        if (gnt0 || gnt1) begin
            if ((gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1)) begin
                hold_d = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
            end else begin
                state_d = gnt1 ? OWN1 : OWN0;
                hold_d  = HOLD_W'(1);
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d = gnt1;
`endif
            // Read+write together counts as a write, so no return strobe.
            rd_pend_d = (gnt0 && m0_read && !m0_write) || (gnt1 && m1_read && !m1_write);
            rd_port_d = gnt1;
        end else begin
            state_d = IDLE;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_port_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
        end
    end

    assign mem_clken      = reset_n;
    assign mem_chipselect = gnt0 | gnt1;
    assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
    assign mem_address    = gnt1 ? m1_address    : (gnt0 ? m0_address    : '0);
    assign mem_byteenable = gnt1 ? m1_byteenable : (gnt0 ? m0_byteenable : '0);
    assign mem_writedata  = gnt1 ? m1_writedata  : (gnt0 ? m0_writedata  : '0);

    assign m0_waitrequest = ~reset_n | (pend0 & ~gnt0);
    assign m1_waitrequest = ~reset_n | (pend1 & ~gnt1);

    assign m0_readdatavalid = reset_n & rd_pend_q & ~rd_port_q;
    assign m1_readdatavalid = reset_n & rd_pend_q &  rd_port_q;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_monitor_memory_arbiter.sv
// Directed bench for monitor_memory_arbiter with a behavioural 2048x32 memory (registered address, 1-cycle read).
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_monitor_memory_arbiter;

    logic        clk;
    logic        reset_n;
    logic [10:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, mem_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    monitor_memory_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:2047];
    logic [31:0] mem_rd_q;
    assign mem_readdata = mem_rd_q;

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
            mem_rd_q <= mem[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    // Inputs change just after the rising edge; checks land on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic exp_g1, prev_g1;

    initial begin
        reset_n = 1'b0;
        idle();
        m0_read  = 1'b1;
        m1_write = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_cs", mem_chipselect, 0);
        check("rst_memwr", mem_write, 0);
        check("rst_clken", mem_clken, 0);
        check("rst_rdv0", m0_readdatavalid, 0);
        check("rst_rdv1", m1_readdatavalid, 0);
        check("rst_rd0", m0_readdata, 0);

        cyc(); reset_n = 1'b1; idle();
        @(negedge clk);
        check("idle_clken", mem_clken, 1);
        check("idle_cs", mem_chipselect, 0);
        check("idle_m0_wait", m0_waitrequest, 0);

        // m0 write then read back at 0x005
        cyc(); drv0(0, 1, 11'h005, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_m0_wait", m0_waitrequest, 0);
        check("wr_cs", mem_chipselect, 1);
        check("wr_memwr", mem_write, 1);
        check("wr_addr", mem_address, 32'h005);
        check("wr_data", mem_writedata, 32'hDEADBEEF);
        cyc(); drv0(1, 0, 11'h005, 4'hF, 32'h0);
        @(negedge clk);
        check("rd_m0_wait", m0_waitrequest, 0);
        check("rd_memwr", mem_write, 0);
        cyc(); idle();
        @(negedge clk);
        check("rd_rdv0", m0_readdatavalid, 1);
        check("rd_data0", m0_readdata, 32'hDEADBEEF);
        check("rd_rdv1", m1_readdatavalid, 0);
        check("rd_data1", m1_readdata, 0);
        cyc();
        @(negedge clk);
        check("rd_rdv0_once", m0_readdatavalid, 0);

        // Partial byte-lane write at the top address
        cyc(); drv1(0, 1, 11'h7FF, 4'hF, 32'hFFFFFFFF);
        cyc(); drv1(0, 1, 11'h7FF, 4'h3, 32'h11223344);
        @(negedge clk);
        check("be_m1_wait", m1_waitrequest, 0);
        check("be_mem_be", mem_byteenable, 32'h3);
        cyc(); idle(); drv0(1, 0, 11'h7FF, 4'hF, 32'h0);
        cyc(); idle();
        @(negedge clk);
        check("be_rdv0", m0_readdatavalid, 1);
        check("be_data0", m0_readdata, 32'hFFFF3344);

        // Read and write both high is a write
        cyc(); drv1(1, 1, 11'h010, 4'hF, 32'hA5A5A5A5);
        @(negedge clk);
        check("rw_memwr", mem_write, 1);
        check("rw_m1_wait", m1_waitrequest, 0);
        cyc(); idle();
        @(negedge clk);
        check("rw_no_rdv1", m1_readdatavalid, 0);
        cyc(); drv1(1, 0, 11'h010, 4'hF, 32'h0);
        cyc(); idle();
        @(negedge clk);
        check("rw_rdv1", m1_readdatavalid, 1);
        check("rw_data1", m1_readdata, 32'hA5A5A5A5);
        check("rw_data0_zero", m0_readdata, 0);

        // Write by m1 then immediate read by m0 sees the new data
        cyc(); drv1(0, 1, 11'h020, 4'hF, 32'h12345678);
        cyc(); idle(); drv0(1, 0, 11'h020, 4'hF, 32'h0);
        @(negedge clk);
        check("wtr_m0_wait", m0_waitrequest, 0);
        cyc(); idle();
        @(negedge clk);
        check("wtr_data0", m0_readdata, 32'h12345678);

        // Ties from IDLE after a fresh reset
        cyc(); reset_n = 1'b0; idle();
        cyc(); reset_n = 1'b1;
        drv0(1, 0, 11'h005, 4'hF, 32'h0); drv1(1, 0, 11'h7FF, 4'hF, 32'h0);
        @(negedge clk);
        check("tie1_m0_wait", m0_waitrequest, 0);
        check("tie1_m1_wait", m1_waitrequest, 1);
        cyc(); idle();
        cyc(); drv0(1, 0, 11'h005, 4'hF, 32'h0); drv1(1, 0, 11'h7FF, 4'hF, 32'h0);
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        check("tie2_m0_wait", m0_waitrequest, 1);
        check("tie2_m1_wait", m1_waitrequest, 0);
`else
        check("tie2_m0_wait", m0_waitrequest, 0);
        check("tie2_m1_wait", m1_waitrequest, 1);
`endif

        // Both ports streaming reads: 4 grants each, alternating
        cyc(); reset_n = 1'b0; idle();
        cyc(); reset_n = 1'b1;
        drv0(1, 0, 11'h005, 4'hF, 32'h0); drv1(1, 0, 11'h7FF, 4'hF, 32'h0);
        prev_g1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_g1 = ((i / 4) % 2) == 1;
            check($sformatf("stream_m0_wait_%0d", i), m0_waitrequest, {31'b0, exp_g1});
            check($sformatf("stream_m1_wait_%0d", i), m1_waitrequest, {31'b0, ~exp_g1});
            if (i > 0) begin
                check($sformatf("stream_rdv0_%0d", i), m0_readdatavalid, {31'b0, ~prev_g1});
                check($sformatf("stream_rdv1_%0d", i), m1_readdatavalid, {31'b0, prev_g1});
                check($sformatf("stream_rd0_%0d", i), m0_readdata, prev_g1 ? 32'h0 : 32'hDEADBEEF);
                check($sformatf("stream_rd1_%0d", i), m1_readdata, prev_g1 ? 32'hFFFF3344 : 32'h0);
            end
            prev_g1 = exp_g1;
            cyc();
        end
        idle();
        @(negedge clk);
        check("stream_last_rdv1", m1_readdatavalid, 1);
        check("stream_last_rdv0", m0_readdatavalid, 0);

        // Reset in the cycle after a read accept drops the return
        cyc(); drv0(1, 0, 11'h005, 4'hF, 32'h0);
        @(negedge clk);
        check("rr_accept", m0_waitrequest, 0);
        cyc(); reset_n = 1'b0; idle();
        @(negedge clk);
        check("rr_rdv0", m0_readdatavalid, 0);
        check("rr_rd0", m0_readdata, 0);
        check("rr_m0_wait", m0_waitrequest, 1);
        check("rr_m1_wait", m1_waitrequest, 1);
        check("rr_cs", mem_chipselect, 0);
        check("rr_clken", mem_clken, 0);
        cyc(); reset_n = 1'b1;
        @(negedge clk);
        check("rr_post_rdv0", m0_readdatavalid, 0);
        check("rr_post_rdv1", m1_readdatavalid, 0);
        cyc(); drv0(1, 0, 11'h005, 4'hF, 32'h0);
        @(negedge clk);
        check("rr_new_accept", m0_waitrequest, 0);
        cyc(); idle();
        @(negedge clk);
        check("rr_new_rdv0", m0_readdatavalid, 1);
        check("rr_new_data0", m0_readdata, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
